// File: rtl/score_display.sv
// Saturating two-digit BCD win/loss tallies, scanned onto a four-digit
// active-low seven-segment display (wins left pair, losses right pair).
module score_display #(
  parameter int REFRESH_N = 17,
  parameter int MAX_SCORE = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       win,
  input  logic       lose,
  input  logic       clear,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam logic [3:0] MAX_TENS = 4'(MAX_SCORE / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_SCORE % 10);

  // Index 0 is the loss tally, index 1 the win tally.
  logic           win_q_reg;
  logic           lose_q_reg;
  logic           win_rise;
  logic           lose_rise;
  logic [1:0]     bump;
  logic [15:0]    digits;

  logic [REFRESH_N-1:0] cnt_reg;
  logic [1:0]           sel;
  logic [3:0]           cur_digit;

  logic [6:0] seg_reg;
  logic [6:0] seg_next;
  logic [3:0] an_reg;
  logic [3:0] an_next;
  logic       dp_reg;
  logic       dp_next;

  assign win_rise  = win & ~win_q_reg;
  assign lose_rise = lose & ~lose_q_reg;

  // Simultaneous rises are an illegal event and are dropped.
  always_comb begin
    bump = 2'b00;
    if (!clear && !(win_rise && lose_rise)) begin
      bump = {win_rise, lose_rise};
    end
  end

  // Held at 1 in reset so a level already present at release is not a rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q_reg  <= 1'b1;
      lose_q_reg <= 1'b1;
    end else begin
      win_q_reg  <= win;
      lose_q_reg <= lose;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_tally
      logic [3:0] tens_reg;
      logic [3:0] ones_reg;
      logic [3:0] tens_next;
      logic [3:0] ones_next;

      always_comb begin
        tens_next = tens_reg;
        ones_next = ones_reg;
        if (clear) begin
          tens_next = 4'd0;
          ones_next = 4'd0;
        end else if (bump[gi]) begin
          if (tens_reg == MAX_TENS && ones_reg == MAX_ONES) begin
            tens_next = tens_reg;
            ones_next = ones_reg;
          end else if (ones_reg == 4'd9) begin
            ones_next = 4'd0;
            tens_next = tens_reg + 4'd1;
          end else begin
            ones_next = ones_reg + 4'd1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          tens_reg <= 4'd0;
          ones_reg <= 4'd0;
        end else begin
          tens_reg <= tens_next;
          ones_reg <= ones_next;
        end
      end

      assign digits[gi*8 +: 8] = {tens_reg, ones_reg};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + REFRESH_N'(1);
    end
  end

  assign sel       = cnt_reg[REFRESH_N-1:REFRESH_N-2];
  assign cur_digit = digits[{sel, 2'b00} +: 4];

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Odd sel values are tens digits, which blank when zero.
  always_comb begin
    an_next  = ~(4'b0001 << sel);
    dp_next  = (sel != 2'd2);
    seg_next = seg_code(cur_digit);
    if (sel[0] && cur_digit == 4'd0) begin
      seg_next = 7'b1111111;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_reg <= 7'b1111111;
      an_reg  <= 4'b1111;
      dp_reg  <= 1'b1;
    end else begin
      seg_reg <= seg_next;
      an_reg  <= an_next;
      dp_reg  <= dp_next;
    end
  end

  assign seg = seg_reg;
  assign an  = an_reg;
  assign dp  = dp_reg;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: vector table of pulses with expected
// tallies, checked against a full display scan, plus carry/saturation/reset runs.
module tb_score_display;

  logic       clk;
  logic       rst;
  logic       win;
  logic       lose;
  logic       clear;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int errors = 0;
  int checks = 0;
  int cyc;

  logic [6:0] seg_tab [10];

  typedef struct {
    string name;
    bit    w;
    bit    l;
    bit    c;
    int    exp_w;
    int    exp_l;
  } vec_t;

  vec_t vecs [8];

  score_display #(.REFRESH_N(4), .MAX_SCORE(99)) dut (
    .clk   (clk),
    .rst   (rst),
    .win   (win),
    .lose  (lose),
    .clear (clear),
    .seg   (seg),
    .an    (an),
    .dp    (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clocks since reset release; display at cycle k reflects counter value k-1.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic logic [11:0] expect_out(int k, int wt, int lt);
    int         s;
    int         d;
    logic [6:0] sg;
    logic [3:0] a;
    s = ((k - 1) % 16) / 4;
    case (s)
      0:       d = lt % 10;
      1:       d = lt / 10;
      2:       d = wt % 10;
      default: d = wt / 10;
    endcase
    sg = seg_tab[d];
    if ((s % 2) == 1 && d == 0) sg = 7'b1111111;
    a = ~(4'b0001 << s);
    return {a, sg, (s != 2)};
  endfunction

  task automatic check_scan(input string name, input int wt, input int lt);
    logic [11:0] exp_v;
    logic [11:0] got_v;
    repeat (16) begin
      @(negedge clk);
      checks++;
      exp_v = expect_out(cyc, wt, lt);
      got_v = {an, seg, dp};
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 name, cyc, got_v[11:8], got_v[7:1], got_v[0],
                 exp_v[11:8], exp_v[7:1], exp_v[0]);
      end
    end
    $display("scan %s win=%0d lose=%0d done", name, wt, lt);
  endtask

  task automatic check_blank(input string name);
    checks++;
    if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
      errors++;
      $display("FAIL %s got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1",
               name, an, seg, dp);
    end else begin
      $display("blank %s ok", name);
    end
  endtask

  // Three clocks high (clear only in the first), then three clocks low.
  task automatic pulse(input bit w, input bit l, input bit c);
    @(posedge clk); #1;
    win = w; lose = l; clear = c;
    @(posedge clk); #1;
    clear = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    win = 1'b0; lose = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;

    vecs[0] = '{"win1",      1'b1, 1'b0, 1'b0, 1, 0};
    vecs[1] = '{"win2",      1'b1, 1'b0, 1'b0, 2, 0};
    vecs[2] = '{"win3",      1'b1, 1'b0, 1'b0, 3, 0};
    vecs[3] = '{"lose1",     1'b0, 1'b1, 1'b0, 3, 1};
    vecs[4] = '{"both_rise", 1'b1, 1'b1, 1'b0, 3, 1};
    vecs[5] = '{"clr_win",   1'b1, 1'b0, 1'b1, 0, 0};
    vecs[6] = '{"lose_only", 1'b0, 1'b1, 1'b0, 0, 1};
    vecs[7] = '{"clr_only",  1'b0, 1'b0, 1'b1, 0, 0};

    rst = 1'b0; win = 1'b1; lose = 1'b0; clear = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_blank("reset_state");

    @(negedge clk);
    rst = 1'b1;
    check_scan("hold_win", 0, 0);
    @(posedge clk); #1;
    win = 1'b0;

    for (int i = 0; i < 8; i++) begin
      pulse(vecs[i].w, vecs[i].l, vecs[i].c);
      check_scan(vecs[i].name, vecs[i].exp_w, vecs[i].exp_l);
    end

    for (int i = 1; i <= 12; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      if (i == 9)  check_scan("win09", 9, 0);
      if (i == 10) check_scan("win10", 10, 0);
    end
    check_scan("win12", 12, 0);

    for (int i = 1; i <= 105; i++) begin
      pulse(1'b0, 1'b1, 1'b0);
      if (i == 99) check_scan("lose99", 12, 99);
    end
    check_scan("lose_sat", 12, 99);

    pulse(1'b0, 1'b0, 1'b1);
    repeat (7) pulse(1'b1, 1'b0, 1'b0);
    repeat (4) pulse(1'b0, 1'b1, 1'b0);
    check_scan("pre_rst", 7, 4);

    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_blank("async_rst");
    @(posedge clk); #1;
    check_blank("rst_held");
    @(negedge clk);
    rst = 1'b1;
    check_scan("post_rst", 0, 0);

    pulse(1'b1, 1'b0, 1'b0);
    check_scan("post_rst_win", 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
